psola_output_streamer: RTL and testbench
========================================

Name: psola_output_streamer

Overview:
- Drains the PSOLA overlap-add output buffer after the PSOLA engine pulses done.
- Reads output_window_len words from BRAM port B (2-cycle read latency).
- Converts each Q.FRAC_BITS accumulator word to a saturated OUT_WIDTH signed sample and streams it downstream on a valid/ready handshake.
- Zeroes every word after reading it, so the next frame accumulates onto a clean buffer.

Parameters:
WINDOW_SIZE, 2048, buffer depth in words; address width is $clog2(WINDOW_SIZE)+1
DATA_WIDTH, 32, BRAM word width (signed accumulator)
FRAC_BITS, 10, fractional bits in the accumulator word
OUT_WIDTH, 16, output sample width (signed)
FIFO_DEPTH, 4, skid FIFO depth; power of 2, at least 4

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
done_in  input  1  one-cycle pulse from PSOLA: buffer ready to drain
window_len_in  input  12  valid word count; sampled only on accepted done_in
read_addr  output  LOG_WINDOW_SIZE+1  BRAM port B read address
read_data  input  DATA_WIDTH  BRAM port B data, valid 2 cycles after read_addr
clear_addr  output  LOG_WINDOW_SIZE+1  BRAM port B write address
clear_en  output  1  write-enable; writes 0 to clear_addr
sample_out  output  OUT_WIDTH  converted sample
sample_valid  output  1  sample_out valid
sample_ready  input  1  downstream accept
busy  output  1  high from accepted done_in until frame_done
frame_done  output  1  one-cycle pulse after the last sample is accepted
overrun  output  1  one-cycle pulse when done_in arrives while busy

Behaviour:
- Reset (async, rst_n_in low): state=IDLE; all outputs 0; FIFO empty; counters 0. Reset mid-frame abandons the frame. Words not yet cleared stay uncleared.
- States and transitions:
  - IDLE: done_in with window_len_in>0 goes to STREAM. Latch len=min(window_len_in, WINDOW_SIZE). Set rd_ptr=0, busy=1 on the next cycle.
  - IDLE: done_in with window_len_in=0 pulses frame_done the next cycle and stays IDLE. No reads, no samples, busy stays 0.
  - STREAM: issue one read per cycle while rd_ptr<len and (fifo_count + inflight) < FIFO_DEPTH. rd_ptr increments on each issue. inflight counts reads issued but not yet returned (0..2).
  - STREAM: when rd_ptr==len, go to DRAIN.
  - DRAIN: wait for inflight==0 and FIFO empty with the final handshake. Then pulse frame_done, clear busy, return to IDLE.
- Read pipeline:
  - The issued address is delayed 2 cycles alongside a valid bit.
  - On return: push the converted sample into the FIFO, and in the same cycle assert clear_en with clear_addr = the returned address.
  - Exactly one clear per word read. Words at or above len are never touched.
- Conversion:
  - s = read_data >>> FRAC_BITS (arithmetic shift).
  - If s > 2^(OUT_WIDTH-1)-1, output 32767 (for OUT_WIDTH=16).
  - If s < -2^(OUT_WIDTH-1), output -32768.
  - Otherwise output s[OUT_WIDTH-1:0].
- Handshake:
  - sample_valid = FIFO not empty; sample_out = FIFO head.
  - Pop when sample_valid && sample_ready.
  - sample_out must stay stable while valid && !ready.
  - With ready held high, throughput is 1 sample/cycle after 3 cycles of initial latency (issue → return → FIFO head).
- Simultaneous events:
  - FIFO push and pop in the same cycle leaves the count unchanged.
  - done_in while busy: ignored. overrun pulses 1 cycle. len and the pointer are unaffected.
  - done_in in the same cycle as frame_done is treated as busy: overrun pulses and done_in is ignored.
- The read and write ports are both BRAM port B. Read and clear addresses differ by 2 entries in the same cycle, so there is no port conflict. The BRAM must be true dual-port on B, or use a separate write port.

Test Plan:
- Load 0x0000_0400, 0x0000_0800, 0xFFFF_FC00 at addr 0..2; done_in with len=3; ready=1 → samples 1, 2, -1 on consecutive cycles. frame_done pulses 1 cycle after the third handshake. BRAM addr 0..2 read 0 afterwards; addr 3 is unchanged.
- Saturation: words 0x7FFF_FFFF and 0x8000_0000 → 32767 and -32768. Word 0x01FF_FC00 (s=32767) passes exactly.
- Backpressure: len=16, toggle ready 1-of-3 cycles → all 16 samples in order, no loss or duplicate. sample_out is stable while stalled. FIFO count never exceeds 4 and inflight never exceeds 2.
- Boundaries: len=0 → frame_done next cycle, no valid, no clear_en. len=2048 → all 2048 words streamed and cleared; read_addr max is 2047.
- done_in pulsed mid-frame → overrun pulse, frame continues unaffected. rst_n_in asserted mid-frame → outputs 0 immediately (async). A new done_in after reset streams correctly.

Source files
------------

// File: rtl/psola_output_streamer.sv
// PSOLA output streamer: drains the overlap-add buffer through BRAM port B,
// converts each Q.FRAC_BITS accumulator word to a saturated OUT_WIDTH sample,
// streams it over valid/ready through a small skid FIFO, and zeroes each word
// as it comes back from the read pipeline. frame_done and overrun are
// registered pulses, visible the cycle after the event that causes them.
module psola_output_streamer #(
    parameter int WINDOW_SIZE = 2048,
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 10,
    parameter int OUT_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              done_in,
    input  logic [11:0]                       window_len_in,
    output logic [$clog2(WINDOW_SIZE):0]      read_addr,
    input  logic [DATA_WIDTH-1:0]             read_data,
    output logic [$clog2(WINDOW_SIZE):0]      clear_addr,
    output logic                              clear_en,
    output logic signed [OUT_WIDTH-1:0]       sample_out,
    output logic                              sample_valid,
    input  logic                              sample_ready,
    output logic                              busy,
    output logic                              frame_done,
    output logic                              overrun
);

    localparam int AW      = $clog2(WINDOW_SIZE) + 1;
    localparam int IW      = $clog2(FIFO_DEPTH);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int OUT_MAX = (2 ** (OUT_WIDTH - 1)) - 1;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

    state_t                       state, state_nxt;
    logic [AW-1:0]                len_q, rd_ptr, len_clip;
    logic                         accept, pop, push, drain_done;
    logic                         frame_done_d, overrun_d;
    logic [AW-1:0]                addr_p0, addr_p1, addr_p2;
    logic                         vld_p0, vld_p1, vld_p2;
    logic [1:0]                   inflight;
    logic signed [OUT_WIDTH-1:0]  sample_p2;
    logic signed [OUT_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
    logic [IW-1:0]                wr_idx, rd_idx;
    logic [CW-1:0]                fifo_count;

    // Arithmetic shift down to the integer part, then clamp to the output range.
    function automatic logic signed [OUT_WIDTH-1:0] sat_sample(
        input logic signed [DATA_WIDTH-1:0] word
    );
        logic signed [DATA_WIDTH-1:0] s;
        logic signed [DATA_WIDTH-1:0] hi;
        logic signed [DATA_WIDTH-1:0] lo;
        s  = word >>> FRAC_BITS;
        hi = DATA_WIDTH'(OUT_MAX);
        lo = ~hi;
        if (s > hi)
            sat_sample = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else if (s < lo)
            sat_sample = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            sat_sample = s[OUT_WIDTH-1:0];
    endfunction

    // Stage p0: issue a read only when the FIFO can absorb every outstanding word.
    assign inflight  = {1'b0, vld_p1} + {1'b0, vld_p2};
    assign addr_p0   = rd_ptr;
    assign vld_p0    = (state == S_STREAM) && (rd_ptr < len_q) &&
                       ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
    assign read_addr = vld_p0 ? addr_p0 : '0;

    // Stage p2: BRAM data returns; convert, push and clear in the same cycle.
    assign sample_p2  = sat_sample($signed(read_data));
    assign push       = vld_p2;
    assign clear_en   = vld_p2;
    assign clear_addr = vld_p2 ? addr_p2 : '0;

    // FIFO head drives the downstream handshake.
    assign sample_valid = (fifo_count != '0);
    assign pop          = sample_valid && sample_ready;
    assign sample_out   = sample_valid ? fifo_mem[rd_idx] : '0;

    // A done_in coinciding with frame_done counts as arriving while busy.
    assign busy       = (state != S_IDLE);
    assign accept     = done_in && (state == S_IDLE) && !frame_done;
    assign drain_done = (inflight == 2'd0) &&
                        ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

    // Clip the requested length to the buffer depth.
    always_comb begin
        len_clip = AW'(window_len_in);
        if (int'(window_len_in) > WINDOW_SIZE)
            len_clip = AW'(WINDOW_SIZE);
    end

    // Next-state and pulse decode.
    always_comb begin
        state_nxt    = state;
        frame_done_d = 1'b0;
        overrun_d    = done_in && (busy || frame_done);
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (window_len_in == '0)
                        frame_done_d = 1'b1;
                    else
                        state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (rd_ptr == len_q)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_done) begin
                    state_nxt    = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and registered status pulses.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= S_IDLE;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= frame_done_d;
            overrun    <= overrun_d;
        end
    end

    // Frame length latch and read pointer.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            len_q  <= '0;
            rd_ptr <= '0;
        end else if (accept) begin
            len_q  <= len_clip;
            rd_ptr <= '0;
        end else if (vld_p0) begin
            rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Stage p1/p2: valid bits of the two-cycle read pipeline.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // Stage p1/p2: read addresses travel with their valid bits.
    always_ff @(posedge clk_in) begin
        addr_p1 <= addr_p0;
        addr_p2 <= addr_p1;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_idx     <= '0;
            rd_idx     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_idx <= wr_idx + IW'(1);
            if (pop)
                rd_idx <= rd_idx + IW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage.
    always_ff @(posedge clk_in) begin
        if (push)
            fifo_mem[wr_idx] <= sample_p2;
    end

endmodule

// File: tb/tb_psola_output_streamer.sv
// Bench for psola_output_streamer: BRAM port-B model with 2-cycle read
// latency, a cycle monitor, table vectors and randomized frames checked
// against an arithmetic reference of the sample conversion.
module tb_psola_output_streamer;

    localparam int WS = 2048;
    localparam int DW = 32;
    localparam int FB = 10;
    localparam int OW = 16;
    localparam int FD = 4;
    localparam int AW = 12;

    logic                 clk_in = 1'b0;
    logic                 rst_n_in;
    logic                 done_in;
    logic [11:0]          window_len_in;
    logic [AW-1:0]        read_addr;
    logic [DW-1:0]        read_data;
    logic [AW-1:0]        clear_addr;
    logic                 clear_en;
    logic signed [OW-1:0] sample_out;
    logic                 sample_valid;
    logic                 sample_ready;
    logic                 busy;
    logic                 frame_done;
    logic                 overrun;

    psola_output_streamer #(
        .WINDOW_SIZE(WS), .DATA_WIDTH(DW), .FRAC_BITS(FB),
        .OUT_WIDTH(OW), .FIFO_DEPTH(FD)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .done_in(done_in),
        .window_len_in(window_len_in), .read_addr(read_addr),
        .read_data(read_data), .clear_addr(clear_addr), .clear_en(clear_en),
        .sample_out(sample_out), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .busy(busy), .frame_done(frame_done),
        .overrun(overrun)
    );

    always #5 clk_in = ~clk_in;

    // BRAM model: port-B read with two register stages, clear write, bench load port.
    logic [DW-1:0] mem [WS];
    logic [DW-1:0] rd_p1;
    logic          ld_en;
    logic [10:0]   ld_addr;
    logic [DW-1:0] ld_data;
    always @(posedge clk_in) begin
        rd_p1     <= mem[read_addr[10:0]];
        read_data <= rd_p1;
        if (clear_en) mem[clear_addr[10:0]] <= '0;
        if (ld_en)    mem[ld_addr] <= ld_data;
    end

    logic [DW-1:0] img [WS];
    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;
    int cur_len = 0;
    int last_done = 0;
    int last_base = 0;

    // Monitor state, written only by the monitor process.
    int ncyc = 0, occ = 0, occ_viol = 0, stab_viol = 0, valid_total = 0;
    int clr_total = 0, clr_bad = 0, fd_total = 0, last_fd = 0;
    int ov_total = 0, last_ov = 0, busy_cycles = 0, max_raddr = 0;
    int got_q[$];
    int hs_q[$];
    logic                 prev_stall = 1'b0;
    logic signed [OW-1:0] prev_out = '0;

    initial begin
        forever begin
            @(negedge clk_in);
            ncyc++;
            if (!rst_n_in) begin
                occ = 0;
                prev_stall = 1'b0;
            end else begin
                if (((occ > 0) != sample_valid) || occ > FD) occ_viol++;
                if (prev_stall && !(sample_valid && sample_out == prev_out)) stab_viol++;
                if (sample_valid) valid_total++;
                if (sample_valid && sample_ready) begin
                    got_q.push_back(int'(sample_out));
                    hs_q.push_back(ncyc);
                end
                if (clear_en) begin
                    clr_total++;
                    if (int'(clear_addr) >= cur_len) clr_bad++;
                end
                if (frame_done) begin fd_total++; last_fd = ncyc; end
                if (overrun)    begin ov_total++; last_ov = ncyc; end
                if (busy) busy_cycles++;
                if (int'(read_addr) > max_raddr) max_raddr = int'(read_addr);
                occ = occ + (clear_en ? 1 : 0) - ((sample_valid && sample_ready) ? 1 : 0);
                prev_stall = sample_valid && !sample_ready;
                prev_out   = sample_out;
            end
        end
    end

    // Downstream ready: always, one cycle in three, or random.
    initial begin
        int rcyc;
        rcyc = 0;
        sample_ready = 1'b1;
        forever begin
            @(posedge clk_in);
            #1;
            rcyc++;
            case (rdy_mode)
                0:       sample_ready = 1'b1;
                1:       sample_ready = (rcyc % 3 == 0);
                default: sample_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference conversion: floor division by 2^FB, then clamp.
    function automatic int model_sample(input logic [31:0] w);
        longint v, q, d;
        d = longint'(1) << FB;
        v = longint'($signed(w));
        if (v >= 0) q = v / d;
        else        q = -((-v + d - 1) / d);
        if (q > 32767)  return 32767;
        if (q < -32768) return -32768;
        return int'(q);
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[0]) w = {{7{w[31]}}, w[24:0]};
        return w;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input int a, input logic [31:0] d);
        img[a]  = d;
        ld_en   = 1'b1;
        ld_addr = 11'(a);
        ld_data = d;
        @(posedge clk_in);
        #1;
        ld_en   = 1'b0;
    endtask

    task automatic pulse_done(input int l, output int cyc);
        @(posedge clk_in);
        #1;
        done_in       = 1'b1;
        window_len_in = 12'(l);
        @(negedge clk_in);
        #1;
        cyc = ncyc;
        @(posedge clk_in);
        #1;
        done_in = 1'b0;
    endtask

    task automatic run_frame(input int len_in, input int mode, input int inject_at, input string tag);
        int n, bg, bc, bb, bf, bo, bs, bv, dcyc, icyc, w, nz;
        n = (len_in > WS) ? WS : len_in;
        cur_len  = n;
        rdy_mode = mode;
        bg = got_q.size(); bc = clr_total; bb = clr_bad; bf = fd_total;
        bo = ov_total; bs = stab_viol; bv = occ_viol;
        icyc = -10;
        pulse_done(len_in, dcyc);
        last_done = dcyc;
        last_base = bg;
        w = 0;
        while (fd_total == bf && w < 4 * n + 100) begin
            @(negedge clk_in);
            #1;
            w++;
            if (inject_at > 0 && w == inject_at) pulse_done(7, icyc);
        end
        check({tag, " frame_done count"}, fd_total - bf, 1);
        check({tag, " sample count"}, got_q.size() - bg, n);
        for (int i = 0; i < n; i++)
            if (bg + i < got_q.size())
                check($sformatf("%s sample[%0d]", tag, i), got_q[bg + i], model_sample(img[i]));
        check({tag, " clear count"}, clr_total - bc, n);
        check({tag, " clears beyond len"}, clr_bad - bb, 0);
        check({tag, " stall stability"}, stab_viol - bs, 0);
        check({tag, " fifo occupancy vs valid"}, occ_viol - bv, 0);
        nz = 0;
        for (int i = 0; i < n; i++) if (mem[i] != '0) nz++;
        check({tag, " uncleared words"}, nz, 0);
        if (n < WS) check({tag, " word at len untouched"}, mem[n], img[n]);
        if (inject_at > 0) begin
            check({tag, " overrun count"}, ov_total - bo, 1);
            check({tag, " overrun cycle"}, last_ov, icyc + 1);
        end else begin
            check({tag, " spurious overrun"}, ov_total - bo, 0);
        end
        check({tag, " busy after frame"}, busy, 0);
    endtask

    typedef struct {
        logic [31:0] word;
        int          exp;
    } vec_t;

    initial begin
        vec_t tbl [12];
        int   d, icyc, bo, bv, bb, bf, len;

        tbl[0]  = '{32'h0000_0400, 1};
        tbl[1]  = '{32'h0000_0800, 2};
        tbl[2]  = '{32'hFFFF_FC00, -1};
        tbl[3]  = '{32'h7FFF_FFFF, 32767};
        tbl[4]  = '{32'h8000_0000, -32768};
        tbl[5]  = '{32'h01FF_FC00, 32767};
        tbl[6]  = '{32'h0200_0000, 32767};
        tbl[7]  = '{32'hFE00_0000, -32768};
        tbl[8]  = '{32'hFDFF_FC00, -32768};
        tbl[9]  = '{32'h0000_03FF, 0};
        tbl[10] = '{32'hFFFF_FFFF, -1};
        tbl[11] = '{32'hFFF0_0000, -1024};

        rst_n_in = 1'b0; done_in = 1'b0; window_len_in = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset control outputs", {sample_valid, busy, frame_done, overrun, clear_en}, 0);
        check("reset read_addr", read_addr, 0);
        check("reset sample_out", sample_out, 0);
        rst_n_in = 1'b1;

        // Basic three-word frame with timing.
        load(0, 32'h0000_0400); load(1, 32'h0000_0800);
        load(2, 32'hFFFF_FC00); load(3, 32'h1234_5678);
        run_frame(3, 0, 0, "basic");
        if (hs_q.size() >= last_base + 3) begin
            check("basic first sample cycle", hs_q[last_base],     last_done + 4);
            check("basic second sample cycle", hs_q[last_base + 1], last_done + 5);
            check("basic third sample cycle", hs_q[last_base + 2], last_done + 6);
            check("basic frame_done cycle", last_fd, hs_q[last_base + 2] + 1);
        end else begin
            check("basic handshake count", hs_q.size() - last_base, 3);
        end

        // Table vectors, conversion and saturation.
        for (int i = 0; i < 12; i++) load(i, tbl[i].word);
        load(12, 32'hDEAD_BEEF);
        run_frame(12, 0, 0, "table");
        for (int i = 0; i < 12; i++)
            if (last_base + i < got_q.size())
                check($sformatf("table vec[%0d]", i), got_q[last_base + i], tbl[i].exp);

        // Backpressure, ready one cycle in three.
        for (int i = 0; i < 17; i++) load(i, rand_word());
        run_frame(16, 1, 0, "backpressure");

        // Zero-length frame.
        bv = valid_total; bb = busy_cycles;
        load(0, 32'h0000_4000);
        run_frame(0, 0, 0, "len0");
        check("len0 frame_done cycle", last_fd, last_done + 1);
        check("len0 no valid", valid_total - bv, 0);
        check("len0 never busy", busy_cycles - bb, 0);

        // done_in mid-frame.
        for (int i = 0; i < 17; i++) load(i, rand_word());
        run_frame(16, 1, 6, "overrun");

        // done_in in the same cycle as frame_done.
        load(0, 32'h0000_0C00); load(1, 32'h0000_1000); load(2, 32'h0000_1400);
        run_frame(2, 0, 0, "fdcoll");
        bo = ov_total; bv = valid_total; bb = busy_cycles; bf = fd_total;
        done_in = 1'b1; window_len_in = 12'd3; icyc = ncyc;
        @(posedge clk_in);
        #1;
        done_in = 1'b0;
        repeat (6) begin @(negedge clk_in); #1; end
        check("fdcoll overrun count", ov_total - bo, 1);
        check("fdcoll overrun cycle", last_ov, icyc + 1);
        check("fdcoll ignored busy", busy_cycles - bb, 0);
        check("fdcoll ignored valid", valid_total - bv, 0);
        check("fdcoll ignored frame_done", fd_total - bf, 0);

        // Full buffer, random ready.
        for (int i = 0; i < WS; i++) load(i, rand_word());
        run_frame(WS, 2, 0, "full");
        check("full max read_addr", max_raddr, WS - 1);

        // Oversized length clips to the buffer depth.
        for (int i = 0; i < WS; i++) img[i] = '0;
        run_frame(4095, 0, 0, "clip");
        check("clip max read_addr", max_raddr, WS - 1);

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 17; i++) load(i, rand_word());
        cur_len = 16; rdy_mode = 1;
        pulse_done(16, d);
        repeat (8) @(negedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("midreset control outputs", {sample_valid, busy, frame_done, overrun, clear_en}, 0);
        check("midreset sample_out", sample_out, 0);
        check("midreset addresses", {read_addr, clear_addr}, 0);
        repeat (2) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        for (int i = 0; i < 17; i++) load(i, rand_word());
        run_frame(16, 0, 0, "after_reset");

        // Randomized frames.
        for (int k = 0; k < 6; k++) begin
            len = $urandom_range(1, 40);
            for (int i = 0; i <= len; i++) load(i, rand_word());
            run_frame(len, 2, (len >= 12) ? $urandom_range(3, 10) : 0, $sformatf("rand%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
